// File: rtl/code_lock_ctrl.sv
// Code lock controller: stores a multi-digit code, checks entries against it and
// enforces a timed lockout after too many wrong attempts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// EMPTY   | no code stored yet; waiting for a save press
// ARMED   | code stored; check presses are compared, save presses ignored
// OPEN    | correct code accepted; any press re-arms
// LOCKOUT | too many wrong checks; all presses discarded until timer expires
module code_lock_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 3,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  save,
    input  logic                                  check,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]         code_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0]         stored_code,
    output logic [1:0]                            status,
    output logic [$clog2(MAX_TRIES+1)-1:0]        tries_left,
    output logic [$clog2(LOCKOUT_CYCLES+1)-1:0]   lock_cnt,
    output logic                                  ok_pulse,
    output logic                                  fail_pulse
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] ARMED   = 2'b01;
    localparam logic [1:0] OPEN    = 2'b10;
    localparam logic [1:0] LOCKOUT = 2'b11;

    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TRIES_ONE = TW'(1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    logic [1:0] state;
    logic       prev_save;
    logic       prev_check;
    logic       save_edge;
    logic       check_edge;

    assign save_edge  = save & ~prev_save;
    assign check_edge = check & ~prev_check;
    assign status     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            stored_code <= '0;
            tries_left  <= TRIES_MAX;
            lock_cnt    <= '0;
            ok_pulse    <= 1'b0;
            fail_pulse  <= 1'b0;
            // Held buttons must be released before they can register again.
            prev_save   <= 1'b1;
            prev_check  <= 1'b1;
        end else begin
            prev_save  <= save;
            prev_check <= check;
            ok_pulse   <= 1'b0;
            fail_pulse <= 1'b0;
            case (state)
                EMPTY: begin
                    if (save_edge) begin
                        stored_code <= code_in;
                        tries_left  <= TRIES_MAX;
                        state       <= ARMED;
                    end
                end
                ARMED: begin
                    if (check_edge) begin
                        if (code_in == stored_code) begin
                            ok_pulse   <= 1'b1;
                            tries_left <= TRIES_MAX;
                            state      <= OPEN;
                        end else begin
                            fail_pulse <= 1'b1;
                            if (tries_left <= TRIES_ONE) begin
                                tries_left <= '0;
                                lock_cnt   <= LOCK_MAX;
                                state      <= LOCKOUT;
                            end else begin
                                tries_left <= tries_left - TRIES_ONE;
                            end
                        end
                    end
                end
                OPEN: begin
                    // Save wins over a simultaneous check so the new code is not lost.
                    if (save_edge) begin
                        stored_code <= code_in;
                        tries_left  <= TRIES_MAX;
                        state       <= ARMED;
                    end else if (check_edge) begin
                        tries_left <= TRIES_MAX;
                        state      <= ARMED;
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt <= LOCK_ONE) begin
                        lock_cnt   <= '0;
                        tries_left <= TRIES_MAX;
                        state      <= ARMED;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: default instance plus a small re-parametrised one,
// driven from vector tables and hand sequences, compared through an expectation queue.
module tb_code_lock_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, save = 1'b0, check = 1'b0;
    logic [11:0] code_in = '0;
    logic [11:0] stored_code;
    logic [1:0]  status;
    logic [1:0]  tries_left;
    logic [4:0]  lock_cnt;
    logic        ok_pulse, fail_pulse;

    code_lock_ctrl dut (
        .clk(clk), .reset(reset), .save(save), .check(check), .code_in(code_in),
        .stored_code(stored_code), .status(status), .tries_left(tries_left),
        .lock_cnt(lock_cnt), .ok_pulse(ok_pulse), .fail_pulse(fail_pulse)
    );

    logic        p_reset = 1'b1, p_save = 1'b0, p_check = 1'b0;
    logic [23:0] p_code_in = '0;
    logic [23:0] p_stored_code;
    logic [1:0]  p_status;
    logic [0:0]  p_tries_left;
    logic [1:0]  p_lock_cnt;
    logic        p_ok_pulse, p_fail_pulse;

    code_lock_ctrl #(.NUM_DIGITS(6), .DIGIT_W(4), .MAX_TRIES(1), .LOCKOUT_CYCLES(2)) dut_p (
        .clk(clk), .reset(p_reset), .save(p_save), .check(p_check), .code_in(p_code_in),
        .stored_code(p_stored_code), .status(p_status), .tries_left(p_tries_left),
        .lock_cnt(p_lock_cnt), .ok_pulse(p_ok_pulse), .fail_pulse(p_fail_pulse)
    );

    typedef struct {
        logic [1:0]  status;
        logic [23:0] stored;
        logic [3:0]  tries;
        logic [7:0]  lock;
        logic        ok;
        logic        fail;
    } out_t;

    typedef struct {
        logic        rst;
        logic        sv;
        logic        ck;
        logic [23:0] code;
        out_t        exp;
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic out_t mk(input logic [1:0] st, input logic [23:0] sc, input logic [3:0] tr,
                                input logic [7:0] lk, input logic ok, input logic fl);
        out_t o;
        o.status = st; o.stored = sc; o.tries = tr; o.lock = lk; o.ok = ok; o.fail = fl;
        return o;
    endfunction

    function automatic vec_t mkv(input logic r, input logic s, input logic c, input logic [23:0] cd,
                                 input logic [1:0] st, input logic [23:0] sc, input logic [3:0] tr,
                                 input logic [7:0] lk, input logic ok, input logic fl);
        vec_t v;
        v.rst = r; v.sv = s; v.ck = c; v.code = cd;
        v.exp = mk(st, sc, tr, lk, ok, fl);
        return v;
    endfunction

    task automatic cmp(input string name, input string fld, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", name, fld, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input bit use_p, input logic rst, input logic sv, input logic ck,
                        input logic [23:0] code, input out_t exp, input string name);
        out_t act, e;
        @(negedge clk);
        if (use_p) begin
            p_reset = rst; p_save = sv; p_check = ck; p_code_in = code;
        end else begin
            reset = rst; save = sv; check = ck; code_in = code[11:0];
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (use_p) begin
            act = mk(p_status, 24'(p_stored_code), 4'(p_tries_left), 8'(p_lock_cnt), p_ok_pulse, p_fail_pulse);
        end else begin
            act = mk(status, 24'(stored_code), 4'(tries_left), 8'(lock_cnt), ok_pulse, fail_pulse);
        end
        e = exp_q.pop_front();
        cmp(name, "status", 24'(act.status), 24'(e.status));
        cmp(name, "stored", act.stored, e.stored);
        cmp(name, "tries",  24'(act.tries), 24'(e.tries));
        cmp(name, "lock",   24'(act.lock), 24'(e.lock));
        cmp(name, "ok",     24'(act.ok), 24'(e.ok));
        cmp(name, "fail",   24'(act.fail), 24'(e.fail));
    endtask

    localparam logic [23:0] C1234 = 24'o1234;
    localparam logic [23:0] C1235 = 24'o1235;
    localparam logic [23:0] C7777 = 24'o7777;
    localparam logic [23:0] C5555 = 24'o5555;
    localparam logic [23:0] PCODE = 24'h9A3F01;
    localparam logic [23:0] PNEW  = 24'h123456;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[15];
        vec_t pv[15];

        tv[0]  = mkv(1, 0, 0, 24'h0,  2'd0, 24'h0, 4'd3, 8'd0,  0, 0);
        tv[1]  = mkv(0, 0, 0, 24'h0,  2'd0, 24'h0, 4'd3, 8'd0,  0, 0);
        tv[2]  = mkv(0, 0, 1, C1234,  2'd0, 24'h0, 4'd3, 8'd0,  0, 0);
        tv[3]  = mkv(0, 1, 0, C1234,  2'd1, C1234, 4'd3, 8'd0,  0, 0);
        tv[4]  = mkv(0, 0, 0, C1234,  2'd1, C1234, 4'd3, 8'd0,  0, 0);
        tv[5]  = mkv(0, 1, 0, C7777,  2'd1, C1234, 4'd3, 8'd0,  0, 0);
        tv[6]  = mkv(0, 0, 1, C1234,  2'd2, C1234, 4'd3, 8'd0,  1, 0);
        tv[7]  = mkv(0, 0, 0, C1234,  2'd2, C1234, 4'd3, 8'd0,  0, 0);
        tv[8]  = mkv(0, 0, 1, 24'h0,  2'd1, C1234, 4'd3, 8'd0,  0, 0);
        tv[9]  = mkv(0, 0, 0, C1235,  2'd1, C1234, 4'd3, 8'd0,  0, 0);
        tv[10] = mkv(0, 0, 1, C1235,  2'd1, C1234, 4'd2, 8'd0,  0, 1);
        tv[11] = mkv(0, 0, 0, C1235,  2'd1, C1234, 4'd2, 8'd0,  0, 0);
        tv[12] = mkv(0, 0, 1, C1235,  2'd1, C1234, 4'd1, 8'd0,  0, 1);
        tv[13] = mkv(0, 0, 0, C1235,  2'd1, C1234, 4'd1, 8'd0,  0, 0);
        tv[14] = mkv(0, 0, 1, C1235,  2'd3, C1234, 4'd0, 8'd16, 0, 1);

        pv[0]  = mkv(1, 0, 0, 24'h0, 2'd0, 24'h0, 4'd1, 8'd0, 0, 0);
        pv[1]  = mkv(0, 0, 0, 24'h0, 2'd0, 24'h0, 4'd1, 8'd0, 0, 0);
        pv[2]  = mkv(0, 1, 0, PCODE, 2'd1, PCODE, 4'd1, 8'd0, 0, 0);
        pv[3]  = mkv(0, 0, 0, PCODE, 2'd1, PCODE, 4'd1, 8'd0, 0, 0);
        pv[4]  = mkv(0, 0, 1, 24'h0, 2'd3, PCODE, 4'd0, 8'd2, 0, 1);
        pv[5]  = mkv(0, 0, 0, 24'h0, 2'd3, PCODE, 4'd0, 8'd1, 0, 0);
        pv[6]  = mkv(0, 0, 0, 24'h0, 2'd1, PCODE, 4'd1, 8'd0, 0, 0);
        pv[7]  = mkv(0, 0, 0, PCODE, 2'd1, PCODE, 4'd1, 8'd0, 0, 0);
        pv[8]  = mkv(0, 0, 1, PCODE, 2'd2, PCODE, 4'd1, 8'd0, 1, 0);
        pv[9]  = mkv(0, 0, 0, PCODE, 2'd2, PCODE, 4'd1, 8'd0, 0, 0);
        pv[10] = mkv(0, 1, 1, PNEW,  2'd1, PNEW,  4'd1, 8'd0, 0, 0);
        pv[11] = mkv(0, 0, 0, PNEW,  2'd1, PNEW,  4'd1, 8'd0, 0, 0);
        pv[12] = mkv(0, 0, 1, 24'h0, 2'd3, PNEW,  4'd0, 8'd2, 0, 1);
        pv[13] = mkv(1, 0, 0, 24'h0, 2'd0, 24'h0, 4'd1, 8'd0, 0, 0);
        pv[14] = mkv(0, 0, 0, 24'h0, 2'd0, 24'h0, 4'd1, 8'd0, 0, 0);

        for (int i = 0; i < 15; i++)
            step(0, tv[i].rst, tv[i].sv, tv[i].ck, tv[i].code, tv[i].exp, $sformatf("tv%0d", i));

        // Lockout countdown with presses (including the correct code) toggling throughout.
        for (int k = 1; k <= 15; k++) begin
            logic b;
            b = k[0];
            step(0, 0, b, b, C1234, mk(2'd3, C1234, 4'd0, 8'(16 - k), 0, 0), $sformatf("lock%0d", k));
        end
        step(0, 0, 0, 0, C1234, mk(2'd1, C1234, 4'd3, 8'd0, 0, 0), "lock_end");
        step(0, 0, 0, 0, C1234, mk(2'd1, C1234, 4'd3, 8'd0, 0, 0), "no_pending");

        // Check held for five cycles with a wrong code counts once.
        step(0, 0, 0, 1, C1235, mk(2'd1, C1234, 4'd2, 8'd0, 0, 1), "hold0");
        for (int k = 1; k < 5; k++)
            step(0, 0, 0, 1, C1235, mk(2'd1, C1234, 4'd2, 8'd0, 0, 0), $sformatf("hold%0d", k));
        step(0, 0, 0, 0, C1235, mk(2'd1, C1234, 4'd2, 8'd0, 0, 0), "hold_rel");

        // Save held through reset must not store until released and pressed again.
        step(0, 1, 1, 0, C5555, mk(2'd0, 24'h0, 4'd3, 8'd0, 0, 0), "rst_save");
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, 0, C5555, mk(2'd0, 24'h0, 4'd3, 8'd0, 0, 0), $sformatf("held%0d", k));
        step(0, 0, 0, 0, C5555, mk(2'd0, 24'h0, 4'd3, 8'd0, 0, 0), "released");
        step(0, 0, 1, 0, C5555, mk(2'd1, C5555, 4'd3, 8'd0, 0, 0), "repress");
        step(0, 0, 0, 1, C5555, mk(2'd2, C5555, 4'd3, 8'd0, 1, 0), "open");
        step(0, 0, 0, 0, C5555, mk(2'd2, C5555, 4'd3, 8'd0, 0, 0), "open_hold");
        // Reset in OPEN overrides a simultaneous save edge.
        step(0, 1, 1, 0, C7777, mk(2'd0, 24'h0, 4'd3, 8'd0, 0, 0), "rst_open");

        for (int i = 0; i < 15; i++)
            step(1, pv[i].rst, pv[i].sv, pv[i].ck, pv[i].code, pv[i].exp, $sformatf("pv%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
